// File: rtl/effect_dyn_compressor.sv
// Two-stage feed-forward compressor: envelope follower, threshold/ratio gain reduction, makeup gain.
// Optional hard ceiling on the compressed path when COMP_HARD_LIMIT_EN is defined.
module effect_dyn_compressor #(
  parameter int DATA_W     = 16,
  parameter int LIMIT_CEIL = 30000
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_valid,
  input  logic                     i_enable,
  input  logic [2:0]               i_level,
  input  logic [1:0]               i_ratio,
  input  logic [3:0]               i_attack_shift,
  input  logic [3:0]               i_release_shift,
  input  logic signed [DATA_W-1:0] i_data,
  output logic signed [DATA_W-1:0] o_data,
  output logic                     o_valid,
  output logic [DATA_W-2:0]        o_env,
  output logic                     o_gr_active
);

  localparam int MW    = DATA_W - 1;
  localparam int GW    = DATA_W + 3;
  localparam int SCALE = DATA_W - 16;
  localparam logic [MW-1:0] MAG_MAX = {MW{1'b1}};

`ifdef COMP_HARD_LIMIT_EN
  localparam bit HARD_LIMIT = 1'b1;
`else
  localparam bit HARD_LIMIT = 1'b0;
`endif
  localparam logic [MW-1:0] CEIL_MAG = MW'(LIMIT_CEIL) << SCALE;

  function automatic logic [MW-1:0] thr_of(input logic [2:0] lvl);
    logic [MW-1:0] base;
    case (lvl)
      3'd0:    base = MW'(28000);
      3'd1:    base = MW'(24000);
      3'd2:    base = MW'(20000);
      3'd3:    base = MW'(16000);
      3'd4:    base = MW'(12000);
      3'd5:    base = MW'(8000);
      3'd6:    base = MW'(4000);
      default: base = MW'(2000);
    endcase
    return base << SCALE;
  endfunction

  function automatic logic [1:0] makeup_of(input logic [2:0] lvl);
    logic [1:0] sh;
    case (lvl)
      3'd0, 3'd1, 3'd2: sh = 2'd0;
      3'd3, 3'd4:       sh = 2'd1;
      3'd5, 3'd6:       sh = 2'd2;
      default:          sh = 2'd3;
    endcase
    return sh;
  endfunction

  logic [MW-1:0]     env;
  logic [MW-1:0]     env_next;
  logic [DATA_W-1:0] in_mag;
  logic [MW-1:0]     in_abs;

  logic              s1_valid;
  logic              s1_enable;
  logic              s1_neg;
  logic [2:0]        s1_level;
  logic [1:0]        s1_ratio;
  logic [MW-1:0]     s1_abs;
  logic [DATA_W-1:0] s1_data;

  logic [MW-1:0]     thr;
  logic              over;
  logic [MW-1:0]     excess;
  logic [2:0]        shift_r;
  logic [MW-1:0]     reduction;
  logic [MW-1:0]     mag;
  logic [GW-1:0]     gain_wide;
  logic [MW-1:0]     gain;
  logic [DATA_W-1:0] gain_ext;
  logic [DATA_W-1:0] comp_data;

  // Stage 1: magnitude (most negative input saturates) and envelope update.
  always_comb begin
    in_mag = i_data[DATA_W-1] ? (~i_data + 1'b1) : i_data;
    in_abs = in_mag[DATA_W-1] ? MAG_MAX : in_mag[MW-1:0];
    if (in_abs > env) env_next = env + ((in_abs - env) >> i_attack_shift);
    else              env_next = env - ((env - in_abs) >> i_release_shift);
  end

  // Stage 2: env already holds the value that includes the sample now in stage 1.
  always_comb begin
    thr       = thr_of(s1_level);
    over      = env > thr;
    excess    = over ? (env - thr) : '0;
    shift_r   = {1'b0, s1_ratio} + 3'd1;
    reduction = excess - (excess >> shift_r);
    mag       = (s1_abs > reduction) ? (s1_abs - reduction) : '0;
    gain_wide = {{(GW-MW){1'b0}}, mag} << makeup_of(s1_level);
    gain      = (gain_wide > {{(GW-MW){1'b0}}, MAG_MAX}) ? MAG_MAX : gain_wide[MW-1:0];
    if (HARD_LIMIT && s1_enable && (gain > CEIL_MAG)) gain = CEIL_MAG;
    gain_ext  = {1'b0, gain};
    comp_data = s1_neg ? (~gain_ext + 1'b1) : gain_ext;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      env         <= '0;
      s1_valid    <= 1'b0;
      s1_enable   <= 1'b0;
      s1_neg      <= 1'b0;
      s1_level    <= '0;
      s1_ratio    <= '0;
      s1_abs      <= '0;
      s1_data     <= '0;
      o_valid     <= 1'b0;
      o_data      <= '0;
      o_gr_active <= 1'b0;
    end else begin
      s1_valid <= i_valid;
      if (i_valid) begin
        env       <= env_next;
        s1_enable <= i_enable;
        s1_neg    <= i_data[DATA_W-1];
        s1_level  <= i_level;
        s1_ratio  <= i_ratio;
        s1_abs    <= in_abs;
        s1_data   <= i_data;
      end
      o_valid <= s1_valid;
      if (s1_valid) begin
        o_data      <= s1_enable ? comp_data : s1_data;
        o_gr_active <= over;
      end
    end
  end

  assign o_env = env;

endmodule

// File: tb/tb_effect_dyn_compressor.sv
// Scoreboard bench for effect_dyn_compressor (DATA_W=16): directed vectors plus random stimulus
// checked against an arithmetic reference model.
module tb_effect_dyn_compressor;
  localparam int DW = 16;

  logic                 i_clk = 1'b0;
  logic                 i_rst;
  logic                 i_valid;
  logic                 i_enable;
  logic [2:0]           i_level;
  logic [1:0]           i_ratio;
  logic [3:0]           i_attack_shift;
  logic [3:0]           i_release_shift;
  logic signed [DW-1:0] i_data;
  logic signed [DW-1:0] o_data;
  logic                 o_valid;
  logic [DW-2:0]        o_env;
  logic                 o_gr_active;

  effect_dyn_compressor #(.DATA_W(DW), .LIMIT_CEIL(30000)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .i_enable(i_enable),
    .i_level(i_level), .i_ratio(i_ratio), .i_attack_shift(i_attack_shift),
    .i_release_shift(i_release_shift), .i_data(i_data), .o_data(o_data),
    .o_valid(o_valid), .o_env(o_env), .o_gr_active(o_gr_active)
  );

  always #5 i_clk = ~i_clk;

  typedef struct { int data; bit gr; int cyc; } exp_t;
  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;
  int   m_env = 0;

  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int thr16(input int lvl);
    int t[8] = '{28000, 24000, 20000, 16000, 12000, 8000, 4000, 2000};
    return t[lvl];
  endfunction

  function automatic int makeup16(input int lvl);
    int m[8] = '{0, 0, 0, 1, 1, 2, 2, 3};
    return m[lvl];
  endfunction

  // Drive one sample for one cycle and push the model's expectation.
  task automatic send(input int data, input bit en, input int lvl, input int ratio,
                      input int att, input int rel, input bit use_ovr = 1'b0, input int ovr = 0);
    int a, thr, exc, red, mag, gain, outv;
    bit gr;
    exp_t e;
    i_valid         = 1'b1;
    i_data          = data[DW-1:0];
    i_enable        = en;
    i_level         = lvl[2:0];
    i_ratio         = ratio[1:0];
    i_attack_shift  = att[3:0];
    i_release_shift = rel[3:0];
    a = (data == -32768) ? 32767 : ((data < 0) ? -data : data);
    if (a > m_env) m_env = m_env + ((a - m_env) >> att);
    else           m_env = m_env - ((m_env - a) >> rel);
    thr  = thr16(lvl);
    gr   = (m_env > thr);
    exc  = gr ? (m_env - thr) : 0;
    red  = exc - (exc >> (ratio + 1));
    mag  = (a > red) ? (a - red) : 0;
    gain = mag * (1 << makeup16(lvl));
    if (gain > 32767) gain = 32767;
`ifdef COMP_HARD_LIMIT_EN
    if (gain > 30000) gain = 30000;
`endif
    outv = en ? ((data < 0) ? -gain : gain) : data;
    if (use_ovr) outv = ovr;
    e.data = outv;
    e.gr   = gr;
    e.cyc  = cyc;
    sb.push_back(e);
    @(negedge i_clk);
    i_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    i_valid = 1'b0;
    repeat (n) @(negedge i_clk);
  endtask

  always @(negedge i_clk) begin
    exp_t e;
    if (o_valid === 1'b1) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_valid: got o_valid=1 o_data=%0d expected no output", o_data);
      end else begin
        e = sb.pop_front();
        check("o_data", int'(o_data), e.data);
        check("o_gr_active", int'(o_gr_active), int'(e.gr));
        check("latency", cyc - e.cyc, 2);
      end
    end
  end

  initial begin
    int r, d, guard;
    i_rst = 1'b1; i_valid = 1'b0; i_enable = 1'b0; i_level = '0; i_ratio = '0;
    i_attack_shift = '0; i_release_shift = '0; i_data = '0;
    repeat (3) @(negedge i_clk);
    check("rst_o_valid", int'(o_valid), 0);
    check("rst_o_data", int'(o_data), 0);
    check("rst_o_env", int'(o_env), 0);
    check("rst_o_gr", int'(o_gr_active), 0);
    i_rst = 1'b0;
    idle(2);

    // Below threshold from env 0, makeup x2.
    send(1000, 1'b1, 3, 1, 4, 0, 1'b1, 2000);
    idle(3);
    check("env_slow_attack", int'(o_env), 62);
    // Bypass.
    send(-1234, 1'b0, 0, 0, 0, 0, 1'b1, -1234);
    idle(3);
    // Compression, symmetric for negative input.
    send(32000, 1'b1, 0, 1, 0, 0, 1'b1, 29000);
    send(-32000, 1'b1, 0, 1, 0, 0, 1'b1, -29000);
    idle(3);
    check("env_comp", int'(o_env), 32000);
    check("gr_comp", int'(o_gr_active), 1);
    // Release.
    send(32000, 1'b1, 0, 1, 0, 4);
    idle(3);
    check("env_rel0", int'(o_env), 32000);
    send(0, 1'b1, 0, 1, 0, 4);
    idle(3);
    check("env_rel1", int'(o_env), 30000);
    idle(6);
    check("env_hold", int'(o_env), 30000);
    // Full-scale negative input.
`ifdef COMP_HARD_LIMIT_EN
    send(-32768, 1'b1, 7, 1, 0, 0, 1'b1, -30000);
`else
    send(-32768, 1'b1, 7, 1, 0, 0, 1'b1, -32767);
`endif
    idle(3);
    check("env_sat", int'(o_env), 32767);

    // Reset with two samples in flight: neither may appear.
    i_valid = 1'b1; i_enable = 1'b1; i_data = 16'sd5000;
    @(negedge i_clk);
    i_data = -16'sd7000; i_rst = 1'b1;
    @(negedge i_clk);
    i_valid = 1'b0;
    @(negedge i_clk);
    check("midrst_o_valid", int'(o_valid), 0);
    check("midrst_o_env", int'(o_env), 0);
    i_rst = 1'b0;
    m_env = 0;
    idle(3);
    check("post_rst_env", int'(o_env), 0);
    send(12000, 1'b1, 4, 2, 0, 3);
    idle(3);

    // Random stimulus with random gaps and back-to-back runs.
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 9) < 7) begin
        r = $urandom_range(0, 15);
        if (r == 0)      d = -32768;
        else if (r == 1) d = 32767;
        else             d = int'($urandom_range(0, 65535)) - 32768;
        send(d, 1'($urandom_range(0, 1)), $urandom_range(0, 7), $urandom_range(0, 3),
             $urandom_range(0, 15), $urandom_range(0, 15));
      end else begin
        idle(1);
      end
      if (i % 50 == 49) begin
        idle(3);
        check("env_rand", int'(o_env), m_env);
      end
    end

    guard = 0;
    while (sb.size() > 0 && guard < 20) begin
      @(negedge i_clk);
      guard++;
    end
    if (sb.size() > 0) begin
      tests++;
      fails++;
      $display("FAIL drain: got %0d outputs pending expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
